// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite encodings and fill-master state type, imported by
// ahb_fill_master.
//   htrans_t        : AHB transfer type
//   HSIZE_WORD      : 32-bit transfer size
//   HBURST_INCR     : undefined-length incrementing burst
//   HPROT_DATA_PRIV : data access, privileged, non-bufferable, non-cacheable
//   fill_state_t    : fill master FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_INCR     = 3'b001;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'b00,
    FILL_XFER = 2'b01,
    FILL_LAST = 2'b10,
    FILL_ERR  = 2'b11
  } fill_state_t;

endpackage

// File: rtl/ahb_fill_master.sv
// ahb_fill_master
// AHB-Lite master that writes word_count copies of a 32-bit pattern to a
// word-aligned region starting at base_addr, using pipelined INCR writes.
// Build option: define FILL_INCR_EN to write fill_data + i to word i (ramp).
//
// Ports
//   HCLK, HRESETn        : clock, synchronous active-low reset
//   start                : command strobe (sampled only when idle)
//   base_addr            : first word address, bits [1:0] ignored
//   word_count           : number of words to write (0 = immediate done)
//   fill_data            : pattern word
//   busy, done, error    : command status; error qualifies done
//   HADDR..HWDATA        : AHB-Lite master outputs, all registered
//   HREADY, HRESP        : AHB-Lite slave response
//   HRDATA               : unused read data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL_IDLE | no command; HTRANS=IDLE, waits for start
// FILL_XFER | issuing address phases; data phase of previous beat overlaps
// FILL_LAST | last address accepted; waiting for final data phase
// FILL_ERR  | slave error seen; waiting for second HRESP cycle to finish
module ahb_fill_master
  import ahb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [31:0]      HRDATA
);

  fill_state_t      state_q;
  htrans_t          htrans_q;
  logic [31:0]      haddr_q;
  logic             hwrite_q;
  logic [2:0]       hburst_q;
  logic [31:0]      hwdata_q;
  logic [31:0]      pat_q;
  logic [CNT_W-1:0] remain_q;
  logic             dphase_q;  // a data phase is outstanding on the bus
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic [31:0] haddr_d;
  logic        unused_inputs;

  assign haddr_d       = haddr_q + 32'd4;
  assign unused_inputs = ^{HRDATA, base_addr[1:0]};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= FILL_IDLE;
      htrans_q <= IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hburst_q <= '0;
      hwdata_q <= '0;
      pat_q    <= '0;
      remain_q <= '0;
      dphase_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        FILL_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= FILL_XFER;
              htrans_q <= NONSEQ;
              haddr_q  <= {base_addr[31:2], 2'b00};
              hwrite_q <= 1'b1;
              hburst_q <= HBURST_INCR;
              pat_q    <= fill_data;
              remain_q <= word_count;
              busy_q   <= 1'b1;
            end
          end
        end
        FILL_XFER: begin
          // First HRESP cycle (HREADY low): drop the pending address at once.
          if (dphase_q && HRESP && !HREADY) begin
            state_q  <= FILL_ERR;
            htrans_q <= IDLE;
            hwrite_q <= 1'b0;
            hburst_q <= '0;
          end else if (HREADY) begin
            hwdata_q <= pat_q;
            dphase_q <= 1'b1;
`ifdef FILL_INCR_EN
            pat_q    <= pat_q + 32'd1;
`endif
            if (remain_q == CNT_W'(1)) begin
              state_q  <= FILL_LAST;
              htrans_q <= IDLE;
              hwrite_q <= 1'b0;
              hburst_q <= '0;
            end else begin
              haddr_q  <= haddr_d;
              // A 1 KB boundary (or 32-bit wrap) restarts the burst.
              htrans_q <= (haddr_d[9:0] == 10'd0) ? NONSEQ : SEQ;
              remain_q <= remain_q - CNT_W'(1);
            end
          end
        end
        FILL_LAST: begin
          if (HRESP && !HREADY) begin
            state_q <= FILL_ERR;
          end else if (HREADY) begin
            state_q  <= FILL_IDLE;
            dphase_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        FILL_ERR: begin
          if (HREADY) begin
            state_q  <= FILL_IDLE;
            dphase_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
          end
        end
        default: state_q <= FILL_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = hburst_q;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;

endmodule

// File: doc/ahb_fill_master.md
# ahb_fill_master

AHB-Lite bus master that fills a word-aligned region of the address map with a 32-bit pattern, freeing the Cortex-M0 from clearing pixel memory before each frame. It sits on the initiator side of the AHB-Lite protocol, issuing pipelined write transfers towards slaves such as the pixel memory. A shared-bus arbiter is outside this block's scope.

## Interface
- CNT_W, 16, width of the word-count input

- HCLK  in  1  clock
- HRESETn  in  1  reset; synchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  32  first word address; bits [1:0] ignored (treated as 0)
- word_count  in  CNT_W  number of words to write
- fill_data  in  32  pattern word
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; 1 = aborted by HRESP
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type
- HWRITE  out  1  1 whenever HTRANS is NONSEQ/SEQ
- HSIZE  out  3  constant 3'b010 (word) when active
- HBURST  out  3  3'b001 (INCR) when active
- HPROT  out  4  constant 4'b0011
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  write data, driven in data phase
- HREADY  in  1  bus ready
- HRESP  in  1  slave error response
- HRDATA  in  32  unused; present for port completeness

## Operation
- FSM states: IDLE, XFER, LAST, ERR.
- IDLE: HTRANS=IDLE. On start with word_count≠0, latch base, count, and pattern, then go to XFER. On start with word_count=0, pulse done (error=0) next cycle without any bus transfer.
- XFER: drive HTRANS/HADDR for word i. A beat is accepted on a cycle with HREADY=1. On acceptance:
  - HWDATA for word i is registered for the following data phase.
  - HADDR advances by 4, modulo 2^32.
  - The remaining count decrements.
- HTRANS is NONSEQ for the first beat and for any beat whose HADDR[9:0]==0 (1 KB boundary, including 32-bit wrap). It is SEQ otherwise.
- When the final address is accepted, drive HTRANS=IDLE and go to LAST.
- LAST: hold HWDATA until HREADY=1, then pulse done (error=0) and return to IDLE.
- Error handling: HRESP=1 with HREADY=0 (first error cycle) forces HTRANS=IDLE in that same registered-next cycle and moves to ERR. ERR waits for HREADY=1, then pulses done with error=1 and returns to IDLE. Remaining words are abandoned.
- HREADY=0: HADDR, HTRANS, and HWDATA are held unchanged.
- start while busy: ignored.
- busy=1 in every state except IDLE. It is 0 in the cycle done is high.
- Reset mid-transfer: on the next HCLK edge with HRESETn=0, all outputs take their reset values and the FSM goes to IDLE. No done pulse is issued.
- Reset values: HADDR=0, HTRANS=2'b00, HWRITE=0, HSIZE=3'b010, HBURST=0, HPROT=4'b0011, HMASTLOCK=0, HWDATA=0, busy=0, done=0, error=0.

## Timing
- start sampled at edge k produces the first NONSEQ, on HADDR=base, in cycle k+1.
- Zero wait states, N words:
  - Address phases occupy cycles k+1..k+N.
  - Data phases occupy cycles k+2..k+N+1.
  - done is high in cycle k+N+2.
- Each wait cycle (HREADY=0) adds exactly one cycle to both the address and data pipelines.
- All outputs are registered. There are no combinational paths from HREADY/HRESP to the outputs.

## Configuration
- FILL_INCR_EN defined: word i carries fill_data + i (32-bit modulo), giving a ramp test pattern.
- FILL_INCR_EN undefined: every word carries fill_data. No data incrementer is synthesised.

## Structure
- Package ahb_pkg holds the shared definitions:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - constants HSIZE_WORD, HBURST_INCR, HPROT_DATA_PRIV
  - fill_state_t
- Single module; no sub-module is warranted.

## Test plan
- base=0x2000_0000, count=4, fill=0xFFFF_FFFF, HREADY=1 → HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x…00/04/08/0C; each HWDATA=0xFFFF_FFFF one cycle later; done at k+6, error=0.
- Same command with HREADY=0 for 2 cycles during beat 2 → HADDR=0x…04 and HWDATA hold stable; done at k+8.
- base=0x2000_03F8, count=4 → beats 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- count=0 → no HTRANS≠IDLE; done=1 at k+1; busy never asserted. With FILL_INCR_EN, fill=0x10, count=3 → HWDATA 0x10, 0x11, 0x12.
- HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on beat 1 → HTRANS=IDLE next cycle; done=1, error=1.
- HRESETn=0 during beat 2 → next edge HTRANS=0, busy=0, done=0; a subsequent start behaves as in the first scenario.
